key_debouncer: RTL
==================

Name: key_debouncer

Overview:
Input-side counterpart to the board LED drivers. It reads one raw, active-low, bouncing pushbutton on the 50 MHz board clock and produces a clean level output. It also produces single-cycle press, release and auto-repeat strobes, plus a wrapping press counter. Downstream logic and LED blinkers consume these outputs instead of sampling raw KEY pins.

Parameters:
- DEBOUNCE_CYCLES, 1000000, stable cycles required to accept a level change (20 ms at 50 MHz); must be >= 2.
- REPEAT_DELAY, 25000000, cycles from the accepted press to the first repeat strobe (500 ms); 0 disables auto-repeat.
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat strobes (100 ms); must be >= 1 when REPEAT_DELAY != 0.
- CNT_W, 25, width of the debounce and repeat timers; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- CLOCK_50  in  1  sole clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- KEY_N  in  1  raw pushbutton, asynchronous to CLOCK_50, 0 = pressed.
- key_level  out  1  debounced state, 1 = pressed.
- press_pulse  out  1  one-cycle strobe on an accepted press.
- release_pulse  out  1  one-cycle strobe on an accepted release.
- repeat_pulse  out  1  one-cycle auto-repeat strobe while held.
- press_count  out  8  number of accepted presses, wraps 255 -> 0.

Behaviour:
- Clocking and reset: one clock, CLOCK_50. RESET_N is asynchronous and active-low. All flops are on CLOCK_50.
- Reset values:
  - synchronizer flops = 1 (released).
  - FSM = RELEASED; both timers = 0.
  - key_level, press_pulse, release_pulse, repeat_pulse = 0; press_count = 0.
- Synchronizer: two flops on KEY_N; the second flop output is ks. FSM and timers use only ks.
- States: RELEASED, PRESS_CHECK, PRESSED, RELEASE_CHECK.
- RELEASED:
  - ks == 0 -> PRESS_CHECK, debounce timer cleared to 0.
- PRESS_CHECK:
  - ks == 1 -> RELEASED (bounce rejected), no strobe.
  - Otherwise the timer increments.
  - When timer == DEBOUNCE_CYCLES-1 and ks == 0 -> PRESSED. On that transition: key_level <= 1, press_pulse <= 1 for exactly one cycle, press_count <= press_count+1 (mod 256), repeat timer <= 0.
- PRESSED:
  - The repeat timer runs when REPEAT_DELAY != 0.
  - repeat_pulse fires REPEAT_DELAY cycles after the press_pulse cycle, then every REPEAT_PERIOD cycles while held.
  - ks == 1 -> RELEASE_CHECK, debounce timer cleared.
- RELEASE_CHECK:
  - Repeat timer frozen; no repeat_pulse is produced.
  - ks == 0 -> back to PRESSED; the repeat timer resumes from its frozen value.
  - When timer == DEBOUNCE_CYCLES-1 and ks == 1 -> RELEASED, key_level <= 0, release_pulse one cycle.
- Latency: the first clock edge sampling KEY_N low is edge 0. With no bounce, press_pulse and key_level rise after edge DEBOUNCE_CYCLES+2. Release is symmetric.
- Pulse exclusivity: at most one of press_pulse, release_pulse and repeat_pulse is high in any cycle. All outputs are registered.
- Bounce rule: any glitch shorter than DEBOUNCE_CYCLES restarts qualification; it never produces a strobe.
- Reset mid-operation: everything returns to reset values immediately, with no pulse in flight. If the key is still held after RESET_N deasserts, a normal press is detected after debounce and press_count becomes 1.
- Width rule: timers saturate logically via the state transitions and never wrap within a state. press_count wraps silently.

Decomposition:
- Shared package key_pkg:
  - state enum key_state_t {RELEASED, PRESS_CHECK, PRESSED, RELEASE_CHECK}.
  - Default timing constants for 50 MHz (DEBOUNCE_20MS, REPEAT_500MS, REPEAT_100MS).
- Sub-module sync_2ff: 2-flop synchronizer with a reset value parameter. The same module is reused for the other KEY/SW inputs.

Test Plan (bench params: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8):
- Clean press: KEY_N 1 -> 0 held -> press_pulse high 1 cycle, 6 edges after the first low sample; key_level=1; press_count=1.
- Bouncy press: KEY_N 0 for 2 cycles, 1 for 1, 0 for 3, 1 for 1, then 0 held -> no strobe during the bounce; exactly one press_pulse, 6 edges after the final falling edge.
- Hold: KEY_N held low 60 cycles after press_pulse -> repeat_pulse at +20, +28, +36, +44, +52 cycles; no other strobes.
- Release: KEY_N back to 1 held -> release_pulse 1 cycle, 6 edges later; key_level=0; no repeat_pulse during RELEASE_CHECK.
- Wrap: 256 clean press/release pairs -> press_count reads 0 after the 256th press_pulse.
- Reset mid-hold: RESET_N low for 3 cycles while in PRESSED with KEY_N held -> all outputs 0 asynchronously; after release of reset, press_pulse after debounce and press_count=1.

Source files
------------

// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared state encoding and 50 MHz timing defaults for key debouncing
package key_pkg;

    typedef enum logic [1:0] {
        RELEASED      = 2'd0,
        PRESS_CHECK   = 2'd1,
        PRESSED       = 2'd2,
        RELEASE_CHECK = 2'd3
    } key_state_t;

    localparam int DEBOUNCE_20MS = 1000000;
    localparam int REPEAT_500MS  = 25000000;
    localparam int REPEAT_100MS  = 5000000;
    localparam int KEY_CNT_W     = 25;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with selectable reset value
module sync_2ff #(
    parameter int   WIDTH       = 1,
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= {WIDTH{RESET_VALUE}};
            q    <= {WIDTH{RESET_VALUE}};
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - debounced pushbutton with press/release/auto-repeat strobes and press counter
module key_debouncer
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
    parameter int REPEAT_DELAY    = REPEAT_500MS,
    parameter int REPEAT_PERIOD   = REPEAT_100MS,
    parameter int CNT_W           = KEY_CNT_W
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       KEY_N,
    output logic       key_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       repeat_pulse,
    output logic [7:0] press_count
);

    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_FIRST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_NEXT   = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam bit               REPEAT_EN  = (REPEAT_DELAY != 0);

    logic             ks;
    key_state_t       state;
    logic [CNT_W-1:0] db_timer;
    logic [CNT_W-1:0] rpt_timer;
    logic             repeating;
    logic [CNT_W-1:0] rpt_target;

    sync_2ff #(
        .WIDTH      (1),
        .RESET_VALUE(1'b1)
    ) u_key_sync (
        .clk  (CLOCK_50),
        .rst_n(RESET_N),
        .d    (KEY_N),
        .q    (ks)
    );

    // First repeat waits the long delay; later ones use the shorter period.
    assign rpt_target = repeating ? RPT_NEXT : RPT_FIRST;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state         <= RELEASED;
            db_timer      <= '0;
            rpt_timer     <= '0;
            repeating     <= 1'b0;
            key_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
            press_count   <= 8'd0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;

            case (state)
                RELEASED: begin
                    db_timer <= '0;
                    if (!ks) begin
                        state <= PRESS_CHECK;
                    end
                end

                PRESS_CHECK: begin
                    if (ks) begin
                        state <= RELEASED;
                    end else if (db_timer == DB_LAST) begin
                        state       <= PRESSED;
                        key_level   <= 1'b1;
                        press_pulse <= 1'b1;
                        press_count <= press_count + 8'd1;
                        rpt_timer   <= '0;
                        repeating   <= 1'b0;
                    end else begin
                        db_timer <= db_timer + CNT_ONE;
                    end
                end

                PRESSED: begin
                    if (ks) begin
                        state    <= RELEASE_CHECK;
                        db_timer <= '0;
                    end else if (REPEAT_EN) begin
                        if (rpt_timer == rpt_target) begin
                            repeat_pulse <= 1'b1;
                            rpt_timer    <= '0;
                            repeating    <= 1'b1;
                        end else begin
                            rpt_timer <= rpt_timer + CNT_ONE;
                        end
                    end
                end

                RELEASE_CHECK: begin
                    // Repeat timer holds here so a release bounce only delays the next repeat.
                    if (!ks) begin
                        state <= PRESSED;
                    end else if (db_timer == DB_LAST) begin
                        state         <= RELEASED;
                        key_level     <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        db_timer <= db_timer + CNT_ONE;
                    end
                end

                default: begin
                    state <= RELEASED;
                end
            endcase
        end
    end

endmodule
